// File: rtl/led_seq_ctrl_if.sv
// Pushbutton inputs and LED/status outputs of the LED sequencer, bundled as one port.
// Latency: none (pure wiring).
// Backpressure: none; buttons are free-running levels, outputs are always valid.
//
// Signals:
//   btn_mode_n  - raw mode pushbutton, active-low, asynchronous
//   btn_speed_n - raw speed pushbutton, active-low, asynchronous
//   led[2:0]    - LED drive, active-high (led[0]=LED1)
//   mode[1:0]   - current mode code
//   speed[1:0]  - current speed code
interface led_seq_ctrl_if;
    logic       btn_mode_n;
    logic       btn_speed_n;
    logic [2:0] led;
    logic [1:0] mode;
    logic [1:0] speed;

    // master drives the buttons and watches the LEDs; slave is the controller
    modport master (
        output btn_mode_n,
        output btn_speed_n,
        input  led,
        input  mode,
        input  speed
    );

    modport slave (
        input  btn_mode_n,
        input  btn_speed_n,
        output led,
        output mode,
        output speed
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED sequencer: debounced mode/speed buttons drive a chase/blink pattern on 3 LEDs.
// Latency: button edge -> press pulse after 2 sync + DEB_CYCLES cycles; press/tick -> outputs next cycle.
// Backpressure: none; a press pulse is consumed in the cycle it occurs.
//
// Ports:
//   clk - system clock, all state on rising edge
//   rst - synchronous active-high reset
//   bus - led_seq_ctrl_if.slave: btn_mode_n/btn_speed_n in, led/mode/speed out (all registered)
module led_seq_ctrl #(
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    led_seq_ctrl_if.slave bus
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [31:0]   TICK_W   = 32'(TICK_DIV);

    typedef enum logic [1:0] {
        CHASE_FWD = 2'd0,
        CHASE_REV = 2'd1,
        BLINK_ALL = 2'd2,
        OFF       = 2'd3
    } mode_t;

    // ------------------------------------------------------------------
    // Button conditioning; index 0 = mode button, index 1 = speed button
    // ------------------------------------------------------------------
    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_db;
    logic [1:0]    r_arm;
    logic [DW-1:0] r_cnt [2];
    logic [1:0]    w_cnt_done;
    logic [1:0]    w_press;

    assign w_raw = {bus.btn_speed_n, bus.btn_mode_n};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_cnt_done[i] = (r_cnt[i] == DEB_LAST);
            // press fires on the cycle the debounced level is about to fall
            w_press[i]    = r_arm[i] & r_db[i] & ~r_sync2[i] & w_cnt_done[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_db    <= 2'b11;
            r_arm   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (!r_arm[i]) begin
                    // After reset a button must be seen released for DEB_CYCLES
                    // before presses count, so a button held through reset is
                    // not mistaken for a new press. Both sync stages must be
                    // high so the reset-loaded 1s cannot arm it.
                    if (!(r_sync1[i] & r_sync2[i])) begin
                        r_cnt[i] <= '0;
                    end else if (w_cnt_done[i]) begin
                        r_cnt[i] <= '0;
                        r_arm[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + DW'(1);
                    end
                end else if (r_sync2[i] != r_db[i]) begin
                    if (w_cnt_done[i]) begin
                        r_cnt[i] <= '0;
                        r_db[i]  <= r_sync2[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + DW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and pattern state
    // ------------------------------------------------------------------
    mode_t         r_mode;
    mode_t         w_mode_nxt;
    logic [1:0]    r_speed;
    logic [1:0]    r_pos;
    logic [1:0]    w_pos_nxt;
    logic          r_phase;
    logic          w_phase_nxt;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_led;
    logic [2:0]    w_led_nxt;
    logic [31:0]   w_period;
    logic          w_any_press;
    logic          w_last;
    logic          w_tick;

    assign w_period    = TICK_W >> r_speed;
    assign w_any_press = w_press[0] | w_press[1];
    assign w_last      = (32'(r_presc) == (w_period - 32'd1));
    // a press restarts the step period, so it also swallows a coincident tick
    assign w_tick      = w_last & ~w_any_press;

    always_comb begin
        w_mode_nxt  = r_mode;
        w_pos_nxt   = r_pos;
        w_phase_nxt = r_phase;
        w_led_nxt   = 3'b000;

        if (w_press[0]) begin
            case (r_mode)
                CHASE_FWD: begin
                    w_mode_nxt = CHASE_REV;
                    w_pos_nxt  = 2'd2;
                end
                CHASE_REV: begin
                    w_mode_nxt  = BLINK_ALL;
                    w_phase_nxt = 1'b1;
                end
                BLINK_ALL: begin
                    w_mode_nxt = OFF;
                end
                default: begin
                    w_mode_nxt = CHASE_FWD;
                    w_pos_nxt  = 2'd0;
                end
            endcase
        end else if (w_tick) begin
            case (r_mode)
                CHASE_FWD: w_pos_nxt   = (r_pos == 2'd2) ? 2'd0 : r_pos + 2'd1;
                CHASE_REV: w_pos_nxt   = (r_pos == 2'd0) ? 2'd2 : r_pos - 2'd1;
                BLINK_ALL: w_phase_nxt = ~r_phase;
                default:   ;  // OFF ignores ticks
            endcase
        end

        case (w_mode_nxt)
            CHASE_FWD,
            CHASE_REV: w_led_nxt = 3'(3'b001 << w_pos_nxt);
            BLINK_ALL: w_led_nxt = {3{w_phase_nxt}};
            default:   w_led_nxt = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= CHASE_FWD;
            r_speed <= 2'd0;
            r_pos   <= 2'd0;
            r_phase <= 1'b1;
            r_presc <= '0;
            r_led   <= 3'b001;
        end else begin
            r_mode  <= w_mode_nxt;
            r_pos   <= w_pos_nxt;
            r_phase <= w_phase_nxt;
            r_led   <= w_led_nxt;
            if (w_press[1]) begin
                r_speed <= r_speed + 2'd1;
            end
            if (w_any_press || w_last) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign bus.led   = r_led;
    assign bus.mode  = r_mode;
    assign bus.speed = r_speed;

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25000000, base step period in clk cycles (0.5 s at 50 MHz); SHALL be >= 8.
REQ-002 Parameter DEB_CYCLES, default 1000000, button stable-time in clk cycles (20 ms); SHALL be >= 2.
REQ-003 Port clk  input  1  50 MHz system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port btn_mode_n  input  1  raw mode pushbutton, active-low, asynchronous to clk.
REQ-006 Port btn_speed_n  input  1  raw speed pushbutton, active-low, asynchronous to clk.
REQ-007 Port led  output  3  registered LED drive, active-high; led[0]=LED1, led[1]=LED2, led[2]=LED3.
REQ-008 Port mode  output  2  current mode code, registered.
REQ-009 Port speed  output  2  current speed code, registered.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Debounced level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-012 Press event: a 1-cycle pulse on the debounced level's 1->0 transition; release generates no event.
REQ-013 Mode FSM: CHASE_FWD(0) -> CHASE_REV(1) -> BLINK_ALL(2) -> OFF(3) -> CHASE_FWD, advancing one state per mode press.
REQ-014 Speed code: increments per speed press, wraps 3->0; step period = TICK_DIV >> speed cycles.
REQ-015 Prescaler counts 0..(period-1); tick asserted for 1 cycle when count == period-1, count then returns to 0.
REQ-016 On any speed or mode press, prescaler SHALL clear to 0 in the same cycle; no tick is issued that cycle.
REQ-017 CHASE_FWD: position pos 0->1->2->0 per tick; led = one-hot, led[pos]=1.
REQ-018 CHASE_REV: pos 2->1->0->2 per tick; led = one-hot, led[pos]=1.
REQ-019 BLINK_ALL: phase toggles per tick; led = 3'b111 when phase=1, 3'b000 when phase=0.
REQ-020 OFF: led = 3'b000; pos and phase frozen; prescaler runs, but its ticks are ignored.
REQ-021 On entry into a mode: CHASE_FWD pos=0, CHASE_REV pos=2, BLINK_ALL phase=1; the new pattern appears on led the cycle after the press pulse.
REQ-022 Latency: tick in cycle N -> led updated in cycle N+1; mode/speed outputs update the cycle after their press pulse.
REQ-023 Simultaneous mode and speed press in the same cycle: both SHALL take effect in that cycle, prescaler cleared once.
REQ-024 Held button: exactly one event per press regardless of hold duration.
REQ-025 Glitches shorter than DEB_CYCLES SHALL produce no event.
REQ-026 led SHALL never show a value other than one-hot, 3'b111 or 3'b000.

Reset
REQ-027 rst=1 at a clk edge: mode=0, speed=0, pos=0, phase=1, prescaler=0, debounce counters=0, synchronizers and debounced levels=1 (released), led=3'b001.
REQ-028 Reset SHALL override any in-progress debounce count or pending tick; no press event is generated on reset exit even if a button is held.
REQ-029 Outputs SHALL hold reset values while rst=1.

Verification (TICK_DIV=16, DEB_CYCLES=4)
REQ-030 Reset, no buttons -> led 001, 010, 100, 001, with steps 16 cycles apart; first step 16 cycles after rst release.
REQ-031 btn_mode_n low for 10 cycles -> mode=1, led=100, then 010 after 16 cycles; four such presses -> mode returns to 0, led=001.
REQ-032 btn_speed_n pressed twice -> speed=2, steps every 4 cycles; a third and fourth press -> speed=3 (2-cycle steps), then wrap to 0 (16-cycle steps).
REQ-033 btn_mode_n low for 2 cycles (glitch) -> no mode change; held low 200 cycles -> exactly one mode increment.
REQ-034 Both buttons pressed on the same cycle while in CHASE_FWD at speed 0 -> mode=1, speed=1, led=100, next step 8 cycles later.
REQ-035 rst asserted mid-BLINK_ALL with btn_mode_n held low -> led=001, mode=0 after the reset edge; no mode change after release of rst until the button is released and pressed again.
